imem_loader: RTL

Boot-time instruction-memory loader for the single-cycle MIPS core.
- Accepts a framed byte stream on a valid/ready input: length byte, program bytes, XOR checksum byte.
- Writes the program bytes into the 32-byte instruction memory and zero-fills the unused tail with NOPs.
- Holds the core's PC at 0 until a good image is loaded.
- Sits directly upstream of the instruction memory / fetch path; its write port drives the memory's byte array and `cpu_hold` gates the PC register update.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and helpers for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEN   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
    localparam logic [STATE_W-1:0] ST_FILL  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERR   = 3'd6;

    // All-zero instruction word is a MIPS NOP, so the tail is filled with zero bytes.
    localparam logic [7:0] NOP_BYTE = 8'h00;

    // A length is usable only if it is a whole number of instructions that fits in memory.
    function automatic logic len_legal(input logic [7:0] n, input int unsigned mem_bytes);
        return (n >= 8'd4) && (32'(n) <= mem_bytes) && (n[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte image (length, program bytes, XOR checksum) into the
// instruction memory, NOP-fills the tail and holds the core until the image is good.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned CW = ADDR_W + 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CW-1:0]      len;
    logic [CW-1:0]      fill_ptr;
    logic [7:0]         csum;
    logic               xfer;
    logic               start_ok;
    logic               last_data;
    logic               len_full;
    logic               fill_end;

    // Input is accepted only while the frame is being received.
    assign in_ready  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHECK);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign last_data = (byte_count + CW'(1)) == len;
    assign len_full  = len == CW'(MEM_BYTES);
    assign fill_end  = fill_ptr == CW'(MEM_BYTES);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (xfer) state_next = len_legal(in_data, MEM_BYTES) ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                if (xfer && last_data) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (in_data != csum) state_next = ST_ERR;
                    else if (len_full)   state_next = ST_DONE;
                    else                 state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_end) state_next = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LEN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs, write port, checksum and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_count <= '0;
            csum       <= 8'h00;
            len        <= '0;
            fill_ptr   <= '0;
        end else begin
            wr_en    <= 1'b0;
            done     <= (state_next == ST_DONE);
            err      <= (state_next == ST_ERR);
            cpu_hold <= (state_next != ST_DONE);

            if (start_ok) begin
                byte_count <= '0;
                csum       <= 8'h00;
            end

            case (state)
                ST_LEN: begin
                    if (xfer) len <= CW'(in_data);
                end
                ST_DATA: begin
                    if (xfer) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= byte_count[ADDR_W-1:0];
                        wr_data    <= in_data;
                        csum       <= csum ^ in_data;
                        byte_count <= byte_count + CW'(1);
                    end
                end
                ST_CHECK: begin
                    // First fill write goes out on the same edge the checksum is accepted.
                    if (xfer && (in_data == csum) && !len_full) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= len[ADDR_W-1:0];
                        wr_data  <= NOP_BYTE;
                        fill_ptr <= len + CW'(1);
                    end
                end
                ST_FILL: begin
                    if (!fill_end) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= fill_ptr[ADDR_W-1:0];
                        wr_data  <= NOP_BYTE;
                        fill_ptr <= fill_ptr + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
